fma_issue_ctrl: RTL
===================

# fma_issue_ctrl

Issue and bypass controller for the fixed-latency FP multiply-accumulate datapath. It accepts decoded FP operations over a valid/ready handshake and tracks in-flight destinations in a shift-register pipeline. It stalls on RAW hazards and drives the datapath's bypass selects, one-hot rounding-mode lines and early-result select. It also produces writeback strobes and accumulates sticky IEEE flags. It sits between FP decode and the FMAC datapath.

## Interface
- LATENCY, 4: stages from issue to result (2..8)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  operation offered
- req_ready  out  1  operation accepted this cycle
- req_rs1 / req_rs2 / req_rs3  in  5 each  X / Y / Z source registers
- req_rd  in  5  destination register
- req_rm  in  3  rounding mode, 111 = dynamic
- req_early  in  1  op result comes from earlyres, not W
- frm  in  3  dynamic rounding mode
- flush  in  1  kill all in-flight ops
- dp_inc, dp_postnorm  in  1 each  final-stage round-up / postnormalize from datapath
- dp_flags  in  4  {invalid, overflow, underflow, inexact} from final stage
- issue  out  1  op enters datapath stage 1
- bypsel  out  2  [0]: W→X, [1]: W→Z
- bypplus1, byppostnorm  out  1 each  bypass corrections
- rn, rz, rm, rp  out  1 each  one-hot rounding for final-stage op
- earlyressel  out  1  final-stage op is early
- wb_valid  out  1  result written this cycle
- wb_rd  out  5  writeback register
- fflags  out  4  sticky accumulated flags
- fflags_clr  in  1  clear fflags

## Operation
- Pipeline: stage[1..LATENCY] registers, each holding {valid, rd, early, rm}. Accepted op enters stage 1 and shifts one stage per cycle. There is no downstream backpressure.
- Final stage = stage[LATENCY]. wb_valid = stage[LATENCY].valid, wb_rd = its rd, earlyressel = valid & early.
- Rounding decode of the final-stage rm (111 replaced by frm at accept): 000 or 100 → rn, 001 → rz, 010 → rm, 011 → rp. Encodings 101/110 → rz. All lines are 0 when the final stage is invalid.
- Hazard check against valid stages k in 1..LATENCY with rd == source:
  - rs1 or rs3 match at k < LATENCY → stall.
  - rs1 or rs3 match at k = LATENCY, final op not early → bypass: bypsel[0] for rs1, bypsel[1] for rs3, both if both match.
  - rs2 match at any k → stall, because Y has no bypass.
  - Early final op matching any source → stall one cycle.
  - The youngest matching stage decides the outcome.
- bypplus1 = dp_inc and byppostnorm = dp_postnorm, only while some bypsel bit is set; otherwise 0.
- req_ready = ~reset & ~flush & ~stall. issue = req_valid & req_ready. bypsel is 0 unless issue.
- fflags |= dp_flags when wb_valid & ~early. fflags_clr wins over a same-cycle set.
- flush clears all stage valids at the clock edge. wb_valid and rounding outputs are still driven that cycle from pre-flush state.

## Timing
- Reset: all stage valids 0, fflags 0. Every output is 0 during and after reset until an op is issued.
- Issue at cycle t → wb_valid at t+LATENCY-1 with the registered final stage. The register-file write completes at that edge.
- Dependent op on rs1/rs3 issues at the earliest LATENCY-1 cycles after its producer, with bypass. On rs2 it issues at the earliest LATENCY cycles after, with no bypass.
- Back-to-back independent ops: one per cycle.
- Reset mid-operation: all in-flight ops are discarded, with no wb_valid.

## Structure
- Package fma_ctrl_pkg: rounding-mode encodings, stage-entry struct, flag bit indices.
- Sub-module fma_ctrl_scoreboard: stage shift register plus hazard/bypass compare. The top level holds the handshake, rounding decode and flags.

## Test plan
- LATENCY=4, independent ops r1..r4 on consecutive cycles → issue 4 cycles in a row; wb_valid for rd=1..4 on cycles 3..6.
- Op rd=5, then consumer rs1=5 offered immediately → req_ready low 2 cycles, issue on the 3rd with bypsel=01. With dp_inc=1 → bypplus1=1.
- Consumer rs1=5, rs3=5 → bypsel=11. Consumer rs2=5 → stalls 3 cycles, bypsel=00.
- req_rm=111, frm=011 → rp=1 only in the final-stage cycle. req_rm=100 → rn=1.
- dp_flags=0001 then 0100 on two writebacks → fflags=0101. fflags_clr coincident with a set → 0000.
- flush with 3 ops in flight → no further wb_valid; req_ready=0 in the flush cycle and 1 the next cycle.

Source files
------------

// File: rtl/fma_ctrl_pkg.sv
// Shared types and constants for the FMAC issue/bypass controller.
// Holds rounding-mode encodings, the pipeline stage-entry struct,
// fflags bit indices and the rounding-mode one-hot decode helper.
package fma_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned FLAG_W = 4;

  // IEEE rounding-mode encodings carried on req_rm / frm
  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;
  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  // Bit positions inside dp_flags / fflags
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_NV = 3;

  // One in-flight operation; rm is already resolved (never RM_DYN)
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             early;
    logic [RM_W-1:0]  rm;
  } stage_t;

  // One-hot rounding lines driven to the datapath
  typedef struct packed {
    logic rn;
    logic rz;
    logic rm;
    logic rp;
  } rnd_t;

  // RMM shares the round-to-nearest datapath; reserved encodings truncate
  function automatic rnd_t rm_decode(input logic [RM_W-1:0] mode);
    rnd_t r;
    r = '0;
    case (mode)
      RM_RNE, RM_RMM: r.rn = 1'b1;
      RM_RTZ:         r.rz = 1'b1;
      RM_RDN:         r.rm = 1'b1;
      RM_RUP:         r.rp = 1'b1;
      default:        r.rz = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fma_ctrl_scoreboard.sv
// In-flight destination tracker and RAW hazard / bypass compare.
// The issue cycle itself is stage 1; stages 2..LATENCY are held in a
// LATENCY-1 deep shift register, the last entry being the final stage.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           drop every in-flight entry at the clock edge
//   push/push_entry op accepted this cycle and its stage entry
//   rs1/rs2/rs3     sources of the op currently offered
//   stall_c         offered op must wait
//   byp_c           bypass candidates {W->Z, W->X}, valid when !stall_c
//   final_entry     final-stage entry (drives writeback and rounding)
module fma_ctrl_scoreboard
  import fma_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  stage_t           push_entry,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rs3,
  output logic             stall_c,
  output logic [1:0]       byp_c,
  output stage_t           final_entry
);

  localparam int unsigned NS = LATENCY - 1;

  stage_t stage_q [NS];
  stage_t stage_d [NS];
  stage_t fin;
  logic   m1, m2, m3;

  // Shift: new op enters the head, everything advances one stage
  always_comb begin
    for (int unsigned i = 0; i < NS; i++) begin
      stage_d[i] = '0;
    end
    if (!flush) begin
      stage_d[0] = push ? push_entry : '0;
      for (int unsigned i = 1; i < NS; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NS; i++) begin
      if (reset) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign fin         = stage_q[NS-1];
  assign final_entry = fin;

  // Any non-final match stalls, so the youngest match always wins over a
  // final-stage bypass; only a match confined to the final stage can bypass.
  always_comb begin
    stall_c = 1'b0;
    byp_c   = 2'b00;
    m1      = fin.valid && (fin.rd == rs1);
    m2      = fin.valid && (fin.rd == rs2);
    m3      = fin.valid && (fin.rd == rs3);
    for (int unsigned i = 0; i + 1 < NS; i++) begin
      if (stage_q[i].valid &&
          ((stage_q[i].rd == rs1) || (stage_q[i].rd == rs2) ||
           (stage_q[i].rd == rs3))) begin
        stall_c = 1'b1;
      end
    end
    // Y has no bypass path; early results are not on W
    if (m2 || ((m1 || m3) && fin.early)) begin
      stall_c = 1'b1;
    end
    if (!fin.early) begin
      byp_c = {m3, m1};
    end
  end

endmodule

// File: rtl/fma_issue_ctrl.sv
// Issue and bypass controller for the fixed-latency FMAC datapath.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_*                         decoded op over valid/ready
//   frm                           dynamic rounding mode
//   flush                         kill all in-flight ops
//   dp_inc/dp_postnorm/dp_flags   final-stage status from the datapath
//   issue                         op enters the datapath this cycle
//   bypsel/bypplus1/byppostnorm   W-bus bypass selects and corrections
//   rn/rz/rm/rp                   one-hot rounding for the final-stage op
//   earlyressel                   final-stage op takes the early result
//   wb_valid/wb_rd                register-file writeback
//   fflags/fflags_clr             sticky IEEE flags and their clear
module fma_issue_ctrl
  import fma_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_W-1:0]  req_rs1,
  input  logic [REG_W-1:0]  req_rs2,
  input  logic [REG_W-1:0]  req_rs3,
  input  logic [REG_W-1:0]  req_rd,
  input  logic [RM_W-1:0]   req_rm,
  input  logic              req_early,
  input  logic [RM_W-1:0]   frm,
  input  logic              flush,
  input  logic              dp_inc,
  input  logic              dp_postnorm,
  input  logic [FLAG_W-1:0] dp_flags,
  output logic              issue,
  output logic [1:0]        bypsel,
  output logic              bypplus1,
  output logic              byppostnorm,
  output logic              rn,
  output logic              rz,
  output logic              rm,
  output logic              rp,
  output logic              earlyressel,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [FLAG_W-1:0] fflags,
  input  logic              fflags_clr
);

  stage_t            push_entry;
  stage_t            fin;
  logic              stall_c;
  logic [1:0]        byp_c;
  logic              fin_v;
  rnd_t              rnd;
  logic [FLAG_W-1:0] fflags_q, fflags_d;

  fma_ctrl_scoreboard #(
    .LATENCY(LATENCY)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (issue),
    .push_entry (push_entry),
    .rs1        (req_rs1),
    .rs2        (req_rs2),
    .rs3        (req_rs3),
    .stall_c    (stall_c),
    .byp_c      (byp_c),
    .final_entry(fin)
  );

  // Handshake; dynamic rounding is resolved at accept so later frm writes
  // do not affect ops already in flight
  always_comb begin
    req_ready        = ~reset & ~flush & ~stall_c;
    issue            = req_valid & req_ready;
    push_entry       = '0;
    push_entry.valid = 1'b1;
    push_entry.rd    = req_rd;
    push_entry.early = req_early;
    push_entry.rm    = (req_rm == RM_DYN) ? frm : req_rm;
  end

  // Bypass selects only mean something for the op actually issuing
  always_comb begin
    bypsel      = issue ? byp_c : 2'b00;
    bypplus1    = (|bypsel) & dp_inc;
    byppostnorm = (|bypsel) & dp_postnorm;
  end

  // Final-stage outputs; reset masks stale state before the first edge
  always_comb begin
    fin_v       = fin.valid & ~reset;
    rnd         = fin_v ? rm_decode(fin.rm) : '0;
    rn          = rnd.rn;
    rz          = rnd.rz;
    rm          = rnd.rm;
    rp          = rnd.rp;
    wb_valid    = fin_v;
    wb_rd       = fin_v ? fin.rd : '0;
    earlyressel = fin_v & fin.early;
  end

  // Sticky flags; early results do not raise IEEE flags, clear wins
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr) begin
      fflags_d = '0;
    end else if (fin_v && !fin.early) begin
      fflags_d = fflags_q | dp_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags = reset ? '0 : fflags_q;

endmodule
